ic_slave_addr_arbiter: RTL and testbench
========================================

Name: ic_slave_addr_arbiter

Overview:
Per-slave address-channel arbiter for the interconnect. It shares one slave's AR or AW channel among NUM_MSTR masters using round-robin and holds the grant until the address handshake completes. It also keeps a per-master outstanding-command count, so no master can push more commands toward this slave than the response registry FIFOs (depth CMD_DEPTH) can hold. One instance sits in front of each slave port, per address channel.

Parameters:
NUM_MSTR, 4, number of requesting masters
MSTR_BITS, 2, width of a master index; must satisfy 2^MSTR_BITS >= NUM_MSTR
CMD_DEPTH, 4, maximum outstanding commands per master toward this slave
CNT_BITS, 3, outstanding counter width; must hold the value CMD_DEPTH

Ports:
clk  in  1  clock
reset  in  1  asynchronous active-high reset
mstr_req  in  NUM_MSTR  per-master AVALID already decoded to this slave
slv_aready  in  1  slave AREADY
resp_done  in  1  pulse: last response beat accepted (VALID&READY&LAST)
resp_mstr  in  MSTR_BITS  master index owning the completed response
grant  out  NUM_MSTR  one-hot grant, registered
grant_mstr  out  MSTR_BITS  encoded index of grant, registered
grant_valid  out  1  a grant is active; the slave AVALID is grant_valid & mstr_req[grant_mstr]
mstr_ready  out  NUM_MSTR  per-master AREADY = grant[i] & slv_aready (combinational)
cmd_full  out  NUM_MSTR  count[i] == CMD_DEPTH
underflow_err  out  1  sticky: resp_done seen with count[resp_mstr]==0

Behaviour:
- Reset (async) values: grant=0, grant_mstr=0, grant_valid=0, all counts=0, underflow_err=0, last_winner=NUM_MSTR-1. With last_winner at NUM_MSTR-1, master 0 has first priority.
- Eligibility: eligible = mstr_req & ~cmd_full.
- FSM state IDLE:
  - If eligible != 0, choose the first eligible index scanning last_winner+1, last_winner+2, ... modulo NUM_MSTR.
  - Register grant, grant_mstr and grant_valid=1; go to GRANT.
  - Arbitration latency is 1 cycle from a request seen in IDLE to grant_valid.
- FSM state GRANT:
  - grant and grant_mstr are held stable.
  - Accept = grant_valid & mstr_req[grant_mstr] & slv_aready.
  - On accept: last_winner <= grant_mstr; count[grant_mstr] increments; grant and grant_valid clear next cycle; return to IDLE.
  - Minimum spacing between two accepts is therefore 2 cycles.
- A master's request must be held until accepted (AXI rule). If mstr_req[grant_mstr] drops while granted, the grant is still held and no accept occurs.
- Index bounds: a chosen index >= NUM_MSTR is impossible. resp_mstr >= NUM_MSTR is ignored.
- Counters, per master, range 0..CMD_DEPTH:
  - Increment on accept for that master.
  - Decrement on resp_done with resp_mstr equal to that master.
  - Increment and decrement in the same cycle for the same master: count unchanged.
- Full: cmd_full[i] masks master i from arbitration only. An already-held grant is not revoked, because the grant was issued while not full and the increment occurs only on accept. Count never exceeds CMD_DEPTH.
- Underflow: resp_done targeting a master with count 0 leaves the count at 0 and sets underflow_err. underflow_err stays set until reset.
- Reset asserted mid-grant: all state clears immediately. Any in-flight handshake in that cycle is discarded.

Test Plan:
- Reset then single requester: mstr_req=4'b0100 -> grant_valid=1 one cycle later with grant=4'b0100 and grant_mstr=2. With slv_aready=1, mstr_ready[2]=1 for exactly 1 cycle, count[2]=1, then grant_valid=0.
- Round-robin fairness: mstr_req=4'b1111 held, slv_aready=1 -> grant order 0,1,2,3,0,1 with accepts every 2 cycles.
- Grant hold under backpressure: master 1 granted, slv_aready=0 for 5 cycles while master 0 also requests -> grant stays 4'b0010 for all 5 cycles. Master 0 is granted only after master 1 is accepted.
- Full limit: CMD_DEPTH=4, master 3 alone gets 4 accepts with no responses -> cmd_full[3]=1 and no 5th grant. One resp_done with resp_mstr=3 -> cmd_full[3]=0 and master 3 is regranted next IDLE cycle.
- Simultaneous events: count[0]=2, then accept for master 0 and resp_done with resp_mstr=0 in the same cycle -> count[0] stays 2. With CMD_DEPTH=4, cmd_full[0]=0.
- Underflow and reset: resp_done with resp_mstr=1 while count[1]=0 -> underflow_err=1 and held. Async reset asserted mid-GRANT -> all outputs 0 in the same cycle.

Source files
------------

// File: rtl/ic_slave_addr_arbiter_if.sv
// Address-channel arbitration bundle between the masters' decoded requests,
// one slave's AREADY/response completion, and the arbiter's grant outputs.
interface ic_slave_addr_arbiter_if #(
  parameter int unsigned NUM_MSTR  = 4,
  parameter int unsigned MSTR_BITS = 2
);
  logic [NUM_MSTR-1:0]  mstr_req;
  logic                 slv_aready;
  logic                 resp_done;
  logic [MSTR_BITS-1:0] resp_mstr;
  logic [NUM_MSTR-1:0]  grant;
  logic [MSTR_BITS-1:0] grant_mstr;
  logic                 grant_valid;
  logic [NUM_MSTR-1:0]  mstr_ready;
  logic [NUM_MSTR-1:0]  cmd_full;
  logic                 underflow_err;

  // Arbiter side
  modport slave (
    input  mstr_req, slv_aready, resp_done, resp_mstr,
    output grant, grant_mstr, grant_valid, mstr_ready, cmd_full, underflow_err
  );

  // Requesting/observing side
  modport master (
    output mstr_req, slv_aready, resp_done, resp_mstr,
    input  grant, grant_mstr, grant_valid, mstr_ready, cmd_full, underflow_err
  );
endinterface

// File: rtl/ic_slave_addr_arbiter.sv
// Round-robin arbiter for one slave's AR/AW channel, holding the grant until the
// address handshake and capping outstanding commands per master at CMD_DEPTH.
module ic_slave_addr_arbiter #(
  parameter int unsigned NUM_MSTR  = 4,
  parameter int unsigned MSTR_BITS = 2,
  parameter int unsigned CMD_DEPTH = 4,
  parameter int unsigned CNT_BITS  = 3
) (
  input  logic                    clk,
  input  logic                    reset,
  ic_slave_addr_arbiter_if.slave  arb
);

  typedef enum logic {IDLE, GRANT} state_t;

  localparam logic [CNT_BITS-1:0]  DEPTH_C  = CNT_BITS'(CMD_DEPTH);
  localparam logic [CNT_BITS-1:0]  ONE_C    = CNT_BITS'(1);
  localparam logic [MSTR_BITS-1:0] LAST_RST = MSTR_BITS'(NUM_MSTR - 1);
  localparam logic [NUM_MSTR-1:0]  BIT0_C   = NUM_MSTR'(1);

  state_t               state_q, state_d;
  logic [NUM_MSTR-1:0]  grant_q, grant_d;
  logic [MSTR_BITS-1:0] grant_mstr_q, grant_mstr_d;
  logic                 grant_valid_q, grant_valid_d;
  logic [MSTR_BITS-1:0] last_winner_q, last_winner_d;
  logic [CNT_BITS-1:0]  count_q [NUM_MSTR];
  logic                 underflow_q;

  logic [NUM_MSTR-1:0]  cmd_full;
  logic [NUM_MSTR-1:0]  eligible;
  logic [NUM_MSTR-1:0]  inc_vec;
  logic [NUM_MSTR-1:0]  dec_vec;
  logic                 underflow_set;
  logic                 pick_found;
  logic [MSTR_BITS-1:0] pick_mstr;
  logic                 accept;

  always_comb begin
    for (int unsigned i = 0; i < NUM_MSTR; i++) begin
      cmd_full[i] = (count_q[i] == DEPTH_C);
    end
  end

  // Full masters drop out of arbitration only; a held grant is never revoked.
  assign eligible = arb.mstr_req & ~cmd_full;
  assign accept   = (state_q == GRANT) && grant_valid_q
                    && arb.mstr_req[grant_mstr_q] && arb.slv_aready;

  // Scan last_winner+1, +2, ... modulo NUM_MSTR and take the first eligible.
  always_comb begin
    int unsigned          idx;
    logic [MSTR_BITS-1:0] cand;
    pick_found = 1'b0;
    pick_mstr  = '0;
    idx        = 0;
    cand       = '0;
    for (int unsigned k = 1; k <= NUM_MSTR; k++) begin
      idx  = (32'(last_winner_q) + k) % NUM_MSTR;
      cand = MSTR_BITS'(idx);
      if (!pick_found && eligible[cand]) begin
        pick_found = 1'b1;
        pick_mstr  = cand;
      end
    end
  end

  always_comb begin
    state_d       = state_q;
    grant_d       = grant_q;
    grant_mstr_d  = grant_mstr_q;
    grant_valid_d = grant_valid_q;
    last_winner_d = last_winner_q;
    case (state_q)
      IDLE: begin
        if (pick_found) begin
          state_d       = GRANT;
          grant_d       = BIT0_C << pick_mstr;
          grant_mstr_d  = pick_mstr;
          grant_valid_d = 1'b1;
        end
      end
      GRANT: begin
        if (accept) begin
          state_d       = IDLE;
          grant_d       = '0;
          grant_valid_d = 1'b0;
          last_winner_d = grant_mstr_q;
        end
      end
      default: begin
        state_d       = IDLE;
        grant_d       = '0;
        grant_valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= IDLE;
      grant_q       <= '0;
      grant_mstr_q  <= '0;
      grant_valid_q <= 1'b0;
      last_winner_q <= LAST_RST;
    end else begin
      state_q       <= state_d;
      grant_q       <= grant_d;
      grant_mstr_q  <= grant_mstr_d;
      grant_valid_q <= grant_valid_d;
      last_winner_q <= last_winner_d;
    end
  end

  // resp_mstr values >= NUM_MSTR match no counter and are therefore ignored.
  always_comb begin
    underflow_set = 1'b0;
    for (int unsigned i = 0; i < NUM_MSTR; i++) begin
      inc_vec[i] = accept && (32'(grant_mstr_q) == i);
      dec_vec[i] = arb.resp_done && (32'(arb.resp_mstr) == i);
      if (dec_vec[i] && (count_q[i] == '0)) begin
        underflow_set = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < NUM_MSTR; i++) begin
        count_q[i] <= '0;
      end
    end else begin
      for (int unsigned i = 0; i < NUM_MSTR; i++) begin
        case ({inc_vec[i], dec_vec[i]})
          2'b10: if (count_q[i] != DEPTH_C) count_q[i] <= count_q[i] + ONE_C;
          2'b01: if (count_q[i] != '0)      count_q[i] <= count_q[i] - ONE_C;
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      underflow_q <= 1'b0;
    end else if (underflow_set) begin
      underflow_q <= 1'b1;
    end
  end

  assign arb.grant         = grant_q;
  assign arb.grant_mstr    = grant_mstr_q;
  assign arb.grant_valid   = grant_valid_q;
  assign arb.mstr_ready    = grant_q & {NUM_MSTR{arb.slv_aready}};
  assign arb.cmd_full      = cmd_full;
  assign arb.underflow_err = underflow_q;

  a_grant_onehot: assert property (@(posedge clk) disable iff (reset)
    $onehot0(grant_q));
  a_valid_matches_grant: assert property (@(posedge clk) disable iff (reset)
    grant_valid_q == (grant_q != '0));

endmodule

// File: tb/tb_ic_slave_addr_arbiter.sv
// Bench for ic_slave_addr_arbiter: directed scenarios plus randomized traffic
// checked against a transaction-level model of grants and outstanding counts.
module tb_ic_slave_addr_arbiter;

  localparam int NM    = 4;
  localparam int DEPTH = 4;

  logic clk;
  logic reset;
  int   n_checks;
  int   n_fail;

  ic_slave_addr_arbiter_if #(.NUM_MSTR(NM), .MSTR_BITS(2)) bus ();

  ic_slave_addr_arbiter #(
    .NUM_MSTR (NM),
    .MSTR_BITS(2),
    .CMD_DEPTH(DEPTH),
    .CNT_BITS (3)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .arb  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: who holds the grant, who won last, outstanding per master.
  bit m_gv;
  int m_gidx;
  int m_last;
  int m_cnt [NM];
  bit m_uf;
  bit n_gv;
  int n_gidx;
  int n_last;
  int n_cnt [NM];
  bit n_uf;

  task automatic model_reset();
    m_gv = 0; m_gidx = 0; m_last = NM - 1; m_uf = 0;
    for (int i = 0; i < NM; i++) m_cnt[i] = 0;
  endtask

  task automatic model_compute();
    bit acc;
    bit found;
    int j;
    acc = m_gv && bus.mstr_req[m_gidx] && bus.slv_aready;
    n_gv = m_gv; n_gidx = m_gidx; n_last = m_last; n_uf = m_uf;
    for (int i = 0; i < NM; i++) n_cnt[i] = m_cnt[i];
    if (!m_gv) begin
      found = 0;
      for (int k = 1; k <= NM; k++) begin
        j = (m_last + k) % NM;
        if (!found && bus.mstr_req[j] && m_cnt[j] < DEPTH) begin
          found = 1; n_gv = 1; n_gidx = j;
        end
      end
    end else if (acc) begin
      n_gv = 0; n_last = m_gidx;
    end
    for (int i = 0; i < NM; i++) begin
      bit inc, dec;
      inc = acc && (m_gidx == i);
      dec = bus.resp_done && (int'(bus.resp_mstr) == i);
      if (dec && m_cnt[i] == 0) n_uf = 1;
      if (inc && !dec && m_cnt[i] < DEPTH) n_cnt[i] = m_cnt[i] + 1;
      if (dec && !inc && m_cnt[i] > 0) n_cnt[i] = m_cnt[i] - 1;
    end
  endtask

  task automatic tick();
    model_compute();
    @(posedge clk);
    #1;
    m_gv = n_gv; m_gidx = n_gidx; m_last = n_last; m_uf = n_uf;
    for (int i = 0; i < NM; i++) m_cnt[i] = n_cnt[i];
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    bus.mstr_req = '0; bus.slv_aready = 1'b0; bus.resp_done = 1'b0; bus.resp_mstr = '0;
    model_reset();
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    n_checks++;
    if (bus.grant !== 4'b0 || bus.grant_valid !== 1'b0 || bus.grant_mstr !== 2'd0) begin
      n_fail++;
      $display("FAIL reset_grant got=%b/%b/%0d exp=0000/0/0", bus.grant, bus.grant_valid, bus.grant_mstr);
    end
    n_checks++;
    if (bus.mstr_ready !== 4'b0 || bus.cmd_full !== 4'b0 || bus.underflow_err !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_misc got ready=%b full=%b uf=%b exp 0000/0000/0", bus.mstr_ready, bus.cmd_full, bus.underflow_err);
    end
  endtask

  task automatic test_single();
    do_reset();
    bus.mstr_req = 4'b0100; bus.slv_aready = 1'b1;
    tick();
    n_checks++;
    if (bus.grant_valid !== 1'b1 || bus.grant !== 4'b0100 || bus.grant_mstr !== 2'd2) begin
      n_fail++;
      $display("FAIL single_grant got=%b/%b/%0d exp=1/0100/2", bus.grant_valid, bus.grant, bus.grant_mstr);
    end
    n_checks++;
    if (bus.mstr_ready !== 4'b0100) begin
      n_fail++;
      $display("FAIL single_ready got=%b exp=0100", bus.mstr_ready);
    end
    tick();
    bus.mstr_req = 4'b0000;
    n_checks++;
    if (bus.grant_valid !== 1'b0 || bus.mstr_ready !== 4'b0000) begin
      n_fail++;
      $display("FAIL single_release got gv=%b ready=%b exp gv=0 ready=0000", bus.grant_valid, bus.mstr_ready);
    end
  endtask

  task automatic test_round_robin();
    logic [3:0] eg;
    do_reset();
    bus.mstr_req = 4'b1111; bus.slv_aready = 1'b1;
    for (int n = 0; n < 6; n++) begin
      tick();
      eg = 4'b0001 << (n % 4);
      n_checks++;
      if (bus.grant_valid !== 1'b1 || bus.grant !== eg || int'(bus.grant_mstr) != n % 4) begin
        n_fail++;
        $display("FAIL rr_order n=%0d got=%b/%0d exp=%b/%0d", n, bus.grant, bus.grant_mstr, eg, n % 4);
      end
      tick();
      n_checks++;
      if (bus.grant_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL rr_gap n=%0d got gv=%b exp=0", n, bus.grant_valid);
      end
    end
  endtask

  task automatic test_back_pressure();
    do_reset();
    bus.mstr_req = 4'b0010; bus.slv_aready = 1'b0;
    tick();
    bus.mstr_req = 4'b0011;
    for (int n = 0; n < 5; n++) begin
      tick();
      n_checks++;
      if (bus.grant !== 4'b0010 || bus.grant_valid !== 1'b1 || bus.mstr_ready !== 4'b0000) begin
        n_fail++;
        $display("FAIL bp_hold n=%0d got=%b gv=%b ready=%b exp=0010/1/0000", n, bus.grant, bus.grant_valid, bus.mstr_ready);
      end
    end
    bus.slv_aready = 1'b1;
    #1;
    n_checks++;
    if (bus.mstr_ready !== 4'b0010) begin
      n_fail++;
      $display("FAIL bp_ready got=%b exp=0010", bus.mstr_ready);
    end
    tick();
    tick();
    n_checks++;
    if (bus.grant !== 4'b0001 || bus.grant_mstr !== 2'd0) begin
      n_fail++;
      $display("FAIL bp_next got=%b/%0d exp=0001/0", bus.grant, bus.grant_mstr);
    end
  endtask

  task automatic test_full();
    do_reset();
    bus.mstr_req = 4'b1000; bus.slv_aready = 1'b1;
    for (int a = 0; a < 4; a++) begin
      tick();
      tick();
    end
    n_checks++;
    if (bus.cmd_full !== 4'b1000) begin
      n_fail++;
      $display("FAIL full_set got=%b exp=1000", bus.cmd_full);
    end
    for (int n = 0; n < 3; n++) begin
      tick();
      n_checks++;
      if (bus.grant_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL full_nogrant n=%0d got gv=%b exp=0", n, bus.grant_valid);
      end
    end
    bus.resp_done = 1'b1; bus.resp_mstr = 2'd3;
    tick();
    bus.resp_done = 1'b0;
    n_checks++;
    if (bus.cmd_full !== 4'b0000 || bus.grant_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL full_clear got full=%b gv=%b exp=0000/0", bus.cmd_full, bus.grant_valid);
    end
    tick();
    n_checks++;
    if (bus.grant_valid !== 1'b1 || bus.grant_mstr !== 2'd3) begin
      n_fail++;
      $display("FAIL full_regrant got gv=%b mstr=%0d exp=1/3", bus.grant_valid, bus.grant_mstr);
    end
  endtask

  task automatic test_simultaneous();
    do_reset();
    bus.mstr_req = 4'b0001; bus.slv_aready = 1'b1;
    repeat (5) tick();
    bus.resp_done = 1'b1; bus.resp_mstr = 2'd0;
    tick();
    bus.resp_done = 1'b0;
    n_checks++;
    if (bus.cmd_full !== 4'b0000 || bus.grant_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL sim_same got full=%b gv=%b exp=0000/0", bus.cmd_full, bus.grant_valid);
    end
    tick();
    tick();
    n_checks++;
    if (bus.cmd_full !== 4'b0000) begin
      n_fail++;
      $display("FAIL sim_three got=%b exp=0000", bus.cmd_full);
    end
    tick();
    tick();
    n_checks++;
    if (bus.cmd_full !== 4'b0001) begin
      n_fail++;
      $display("FAIL sim_four got=%b exp=0001", bus.cmd_full);
    end
  endtask

  task automatic test_underflow_reset();
    do_reset();
    bus.resp_done = 1'b1; bus.resp_mstr = 2'd1;
    tick();
    bus.resp_done = 1'b0;
    for (int n = 0; n < 4; n++) begin
      n_checks++;
      if (bus.underflow_err !== 1'b1 || bus.cmd_full !== 4'b0000) begin
        n_fail++;
        $display("FAIL uf_sticky n=%0d got uf=%b full=%b exp=1/0000", n, bus.underflow_err, bus.cmd_full);
      end
      tick();
    end
    bus.mstr_req = 4'b0010; bus.slv_aready = 1'b0;
    tick();
    n_checks++;
    if (bus.grant_valid !== 1'b1 || bus.grant !== 4'b0010) begin
      n_fail++;
      $display("FAIL rst_pre got gv=%b grant=%b exp=1/0010", bus.grant_valid, bus.grant);
    end
    bus.slv_aready = 1'b1;
    #2;
    reset = 1'b1;
    #1;
    n_checks++;
    if (bus.grant !== 4'b0 || bus.grant_valid !== 1'b0 || bus.grant_mstr !== 2'd0 ||
        bus.mstr_ready !== 4'b0 || bus.underflow_err !== 1'b0 || bus.cmd_full !== 4'b0) begin
      n_fail++;
      $display("FAIL rst_async got grant=%b gv=%b mstr=%0d ready=%b uf=%b full=%b exp all 0",
               bus.grant, bus.grant_valid, bus.grant_mstr, bus.mstr_ready, bus.underflow_err, bus.cmd_full);
    end
    model_reset();
    bus.mstr_req = '0; bus.slv_aready = 1'b0;
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_random();
    logic [3:0] eg;
    logic [3:0] ef;
    logic [3:0] rq;
    int         rm;
    do_reset();
    for (int cyc = 0; cyc < 1500; cyc++) begin
      rq = 4'($urandom);
      if (m_gv && bus.mstr_req[m_gidx] && $urandom_range(0, 9) != 0) rq[m_gidx] = 1'b1;
      bus.mstr_req   = rq;
      bus.slv_aready = ($urandom_range(0, 2) != 0);
      rm             = $urandom_range(0, NM - 1);
      bus.resp_mstr  = 2'(rm);
      bus.resp_done  = ($urandom_range(0, 2) == 0) && (m_cnt[rm] > 0 || $urandom_range(0, 19) == 0);
      tick();
      eg = m_gv ? 4'(1 << m_gidx) : 4'b0000;
      ef = '0;
      for (int i = 0; i < NM; i++) ef[i] = (m_cnt[i] == DEPTH);
      n_checks++;
      if (bus.grant_valid !== m_gv || bus.grant !== eg) begin
        n_fail++;
        $display("FAIL rand_grant cyc=%0d got=%b/%b exp=%b/%b", cyc, bus.grant_valid, bus.grant, m_gv, eg);
      end
      if (m_gv) begin
        n_checks++;
        if (int'(bus.grant_mstr) != m_gidx) begin
          n_fail++;
          $display("FAIL rand_mstr cyc=%0d got=%0d exp=%0d", cyc, bus.grant_mstr, m_gidx);
        end
      end
      n_checks++;
      if (bus.cmd_full !== ef) begin
        n_fail++;
        $display("FAIL rand_full cyc=%0d got=%b exp=%b", cyc, bus.cmd_full, ef);
      end
      n_checks++;
      if (bus.underflow_err !== m_uf) begin
        n_fail++;
        $display("FAIL rand_uf cyc=%0d got=%b exp=%b", cyc, bus.underflow_err, m_uf);
      end
      n_checks++;
      if (bus.mstr_ready !== (eg & {4{bus.slv_aready}})) begin
        n_fail++;
        $display("FAIL rand_ready cyc=%0d got=%b exp=%b", cyc, bus.mstr_ready, eg & {4{bus.slv_aready}});
      end
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    reset    = 1'b1;
    bus.mstr_req = '0; bus.slv_aready = 1'b0; bus.resp_done = 1'b0; bus.resp_mstr = '0;
    model_reset();
    test_reset();
    test_single();
    test_round_robin();
    test_back_pressure();
    test_full();
    test_simultaneous();
    test_underflow_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
